voice_allocator: RTL and testbench

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

---
 rtl/voice_allocator_pkg.sv | 20 ++
 rtl/voice_allocator_slot.sv | 71 +++++++
 rtl/voice_allocator.sv | 145 ++++++++++++++
 tb/tb_voice_allocator.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_allocator_pkg.sv
// Shared types and constants for the polyphonic voice allocator.
package voice_allocator_pkg;

  typedef enum logic [1:0] {
    V_FREE    = 2'd0,
    V_ON      = 2'd1,
    V_RELEASE = 2'd2
  } voice_state_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECIDE = 2'd1,
    S_REGAP  = 2'd2
  } ctrl_state_t;

  localparam int unsigned AGE_W = 8;
  localparam int unsigned REL_W = 16;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

endpackage

// File: rtl/voice_allocator_slot.sv
// One voice channel: lifecycle state, stored note/freq, saturating age and release countdown.
module voice_slot
  import voice_allocator_pkg::*;
#(
  parameter int unsigned      FREQ_BITS      = 16,
  parameter logic [REL_W-1:0] RELEASE_CYCLES = 16'd48000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_alloc,
  input  logic                 i_gap,
  input  logic                 i_release,
  input  logic [6:0]           i_note,
  input  logic [FREQ_BITS-1:0] i_freq,
  output voice_state_t         o_state,
  output logic [6:0]           o_note,
  output logic [FREQ_BITS-1:0] o_freq,
  output logic [AGE_W-1:0]     o_age,
  output logic                 o_gate
);

  voice_state_t         r_state;
  logic [6:0]           r_note;
  logic [FREQ_BITS-1:0] r_freq;
  logic [AGE_W-1:0]     r_age;
  logic [REL_W-1:0]     r_rel_cnt;
  logic                 r_gap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= V_FREE;
      r_note    <= '0;
      r_freq    <= '0;
      r_age     <= '0;
      r_rel_cnt <= '0;
      r_gap     <= 1'b0;
    end else begin
      r_gap <= 1'b0;
      // Allocation outranks a release expiring on the same edge.
      if (i_alloc) begin
        r_state   <= V_ON;
        r_note    <= i_note;
        r_freq    <= i_freq;
        r_age     <= '0;
        r_rel_cnt <= '0;
        r_gap     <= i_gap;
      end else begin
        if (r_state != V_FREE && r_age != AGE_MAX) r_age <= r_age + AGE_W'(1);
        if (i_release) begin
          r_state   <= V_RELEASE;
          r_rel_cnt <= RELEASE_CYCLES;
        end else if (r_state == V_RELEASE) begin
          if (r_rel_cnt <= REL_W'(1)) begin
            r_state   <= V_FREE;
            r_rel_cnt <= '0;
            r_age     <= '0;
          end else begin
            r_rel_cnt <= r_rel_cnt - REL_W'(1);
          end
        end
      end
    end
  end

  assign o_state = r_state;
  assign o_note  = r_note;
  assign o_freq  = r_freq;
  assign o_age   = r_age;
  assign o_gate  = (r_state == V_ON) && !r_gap;

endmodule

// File: rtl/voice_allocator.sv
// Note-event allocator: maps note-on/off events onto NUM_VOICES slots with retrigger and voice stealing.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int unsigned      NUM_VOICES     = 4,
  parameter int unsigned      FREQ_BITS      = 16,
  parameter logic [REL_W-1:0] RELEASE_CYCLES = 16'd48000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ev_valid,
  output logic                            ev_ready,
  input  logic                            ev_note_on,
  input  logic [6:0]                      ev_note,
  input  logic [FREQ_BITS-1:0]            ev_freq,
  output logic [NUM_VOICES*FREQ_BITS-1:0] voice_freq,
  output logic [NUM_VOICES-1:0]           voice_gate,
  output logic                            steal_pulse
);

  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  ctrl_state_t          r_state, w_state_nxt;
  logic                 r_note_on;
  logic [6:0]           r_note;
  logic [FREQ_BITS-1:0] r_freq;

  voice_state_t         w_vstate [NUM_VOICES];
  logic [6:0]           w_vnote  [NUM_VOICES];
  logic [AGE_W-1:0]     w_vage   [NUM_VOICES];
  logic [NUM_VOICES-1:0] w_alloc, w_release;

  logic             w_hit, w_off_hit, w_free, w_rel, w_on;
  logic [IDX_W-1:0] w_hit_idx, w_off_idx, w_free_idx, w_rel_idx, w_on_idx, w_tgt;
  logic [AGE_W-1:0] w_rel_age, w_on_age;
  logic             w_do_alloc, w_do_rel, w_gap, w_steal;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_note_on <= 1'b0;
      r_note    <= '0;
      r_freq    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (ev_valid && ev_ready) begin
        r_note_on <= ev_note_on;
        r_note    <= ev_note;
        r_freq    <= ev_freq;
      end
    end
  end

  // Candidate scan: strict '>' on age keeps the lowest index on ties.
  always_comb begin
    w_hit = 1'b0;  w_hit_idx  = '0;
    w_off_hit = 1'b0; w_off_idx = '0;
    w_free = 1'b0; w_free_idx = '0;
    w_rel = 1'b0;  w_rel_idx  = '0; w_rel_age = '0;
    w_on = 1'b0;   w_on_idx   = '0; w_on_age  = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (!w_hit && w_vstate[i] != V_FREE && w_vnote[i] == r_note) begin
        w_hit = 1'b1; w_hit_idx = IDX_W'(i);
      end
      if (!w_off_hit && w_vstate[i] == V_ON && w_vnote[i] == r_note) begin
        w_off_hit = 1'b1; w_off_idx = IDX_W'(i);
      end
      if (!w_free && w_vstate[i] == V_FREE) begin
        w_free = 1'b1; w_free_idx = IDX_W'(i);
      end
      if (w_vstate[i] == V_RELEASE && (!w_rel || w_vage[i] > w_rel_age)) begin
        w_rel = 1'b1; w_rel_idx = IDX_W'(i); w_rel_age = w_vage[i];
      end
      if (w_vstate[i] == V_ON && (!w_on || w_vage[i] > w_on_age)) begin
        w_on = 1'b1; w_on_idx = IDX_W'(i); w_on_age = w_vage[i];
      end
    end
  end

  always_comb begin
    w_do_alloc = 1'b0;
    w_do_rel   = 1'b0;
    w_gap      = 1'b0;
    w_steal    = 1'b0;
    w_tgt      = '0;
    if (r_note_on) begin
      w_do_alloc = 1'b1;
      if (w_hit) begin
        w_tgt = w_hit_idx; w_gap = 1'b1;
      end else if (w_free) begin
        w_tgt = w_free_idx;
      end else if (w_rel) begin
        w_tgt = w_rel_idx; w_gap = 1'b1;
      end else begin
        w_tgt = w_on_idx; w_gap = 1'b1; w_steal = w_on;
      end
    end else if (w_off_hit) begin
      w_do_rel = 1'b1;
      w_tgt    = w_off_idx;
    end
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      w_alloc[i]   = (r_state == S_DECIDE) && w_do_alloc && (w_tgt == IDX_W'(i));
      w_release[i] = (r_state == S_DECIDE) && w_do_rel   && (w_tgt == IDX_W'(i));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    ev_ready    = 1'b0;
    steal_pulse = 1'b0;
    case (r_state)
      S_IDLE: begin
        ev_ready = 1'b1;
        if (ev_valid) w_state_nxt = S_DECIDE;
      end
      S_DECIDE: begin
        steal_pulse = w_steal;
        w_state_nxt = (w_do_alloc && w_gap) ? S_REGAP : S_IDLE;
      end
      S_REGAP:  w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    voice_slot #(
      .FREQ_BITS      (FREQ_BITS),
      .RELEASE_CYCLES (RELEASE_CYCLES)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .i_alloc   (w_alloc[g]),
      .i_gap     (w_gap),
      .i_release (w_release[g]),
      .i_note    (r_note),
      .i_freq    (r_freq),
      .o_state   (w_vstate[g]),
      .o_note    (w_vnote[g]),
      .o_freq    (voice_freq[g*FREQ_BITS +: FREQ_BITS]),
      .o_age     (w_vage[g]),
      .o_gate    (voice_gate[g])
    );
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Randomised scoreboard bench for voice_allocator against an edge-timestamped voice model.
module tb_voice_allocator;

  localparam int NV  = 4;
  localparam int FB  = 16;
  localparam int RCI = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ev_valid = 1'b0;
  logic          ev_ready;
  logic          ev_note_on = 1'b0;
  logic [6:0]    ev_note = '0;
  logic [FB-1:0] ev_freq = '0;
  logic [NV*FB-1:0] voice_freq;
  logic [NV-1:0] voice_gate;
  logic          steal_pulse;

  voice_allocator #(
    .NUM_VOICES     (NV),
    .FREQ_BITS      (FB),
    .RELEASE_CYCLES (16'(RCI))
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_note_on  (ev_note_on),
    .ev_note     (ev_note),
    .ev_freq     (ev_freq),
    .voice_freq  (voice_freq),
    .voice_gate  (voice_gate),
    .steal_pulse (steal_pulse)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  typedef struct {
    logic [NV-1:0]    gate;
    logic [NV*FB-1:0] freq;
    bit               steal;
    bit               gap;
    int               tgt;
  } exp_t;
  exp_t exp_q[$];

  // Model: a voice is busy from its allocation edge; a released voice is free from m_freeat on.
  bit            m_used [NV];
  bit            m_on   [NV];
  int            m_note [NV];
  logic [FB-1:0] m_freq [NV];
  int unsigned   m_alloc[NV];
  int unsigned   m_freeat[NV];

  function automatic bit m_free(int v, int unsigned h);
    return !m_used[v] || (!m_on[v] && h >= m_freeat[v]);
  endfunction

  function automatic int m_age(int v, int unsigned h);
    int unsigned d = h - m_alloc[v];
    return (d > 255) ? 255 : int'(d);
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_used[v] = 0; m_on[v] = 0; m_note[v] = -1; m_freq[v] = '0;
      m_alloc[v] = 0; m_freeat[v] = 0;
    end
  endtask

  // h is the index of the handshake edge; decisions see voice state just after it.
  task automatic model_event(input bit on, input int note, input logic [FB-1:0] f,
                             input int unsigned h, output exp_t e);
    int t = -1;
    e.steal = 0; e.gap = 0;
    if (on) begin
      for (int v = 0; v < NV; v++)
        if (t < 0 && !m_free(v, h) && m_note[v] == note) t = v;
      if (t >= 0) e.gap = 1;
      else begin
        for (int v = 0; v < NV; v++) if (t < 0 && m_free(v, h)) t = v;
        if (t < 0) begin
          for (int v = 0; v < NV; v++)
            if (!m_on[v] && (t < 0 || m_age(v, h) > m_age(t, h))) t = v;
          if (t < 0) begin
            for (int v = 0; v < NV; v++)
              if (t < 0 || m_age(v, h) > m_age(t, h)) t = v;
            e.steal = 1;
          end
          e.gap = 1;
        end
      end
      m_used[t] = 1; m_on[t] = 1; m_note[t] = note; m_freq[t] = f; m_alloc[t] = h + 1;
    end else begin
      for (int v = 0; v < NV; v++)
        if (t < 0 && !m_free(v, h) && m_on[v] && m_note[v] == note) t = v;
      if (t >= 0) begin
        m_on[t] = 0; m_freeat[t] = h + 1 + RCI;
      end
    end
    e.tgt = t;
    for (int v = 0; v < NV; v++) begin
      e.gate[v] = m_used[v] && m_on[v];
      e.freq[v*FB +: FB] = m_freq[v];
    end
  endtask

  // Called at #1 after a rising edge; returns at #1 after the handshake edge.
  task automatic send(input bit on, input int note, input logic [FB-1:0] f);
    exp_t e;
    int n = 0;
    ev_valid = 1'b1; ev_note_on = on; ev_note = 7'(note); ev_freq = f;
    while (!ev_ready && n < 10) begin @(posedge clk); #1; n++; end
    if (!ev_ready) begin
      n_cmp++; n_err++;
      $display("FAIL ready_timeout: ev_ready stayed 0, required 1");
      ev_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    ev_valid = 1'b0;
    model_event(on, note, f, cyc, e);
    exp_q.push_back(e);
  endtask

  bit mon_en = 0;
  bit busy = 0;

  initial begin : monitor
    int k, steals;
    bit gapped;
    logic [NV-1:0] gap_gate, one;
    exp_t e;
    k = 0; steals = 0; gapped = 0; gap_gate = '0; one = 1;
    forever begin
      @(negedge clk);
      if (!mon_en) busy = 0;
      else begin
        if (busy) begin
          k++;
          if (steal_pulse) steals++;
          if (k == 2 && !ev_ready) begin gapped = 1; gap_gate = voice_gate; end
          if (ev_ready || k >= 4) begin
            busy = 0;
            if (exp_q.size() == 0) begin
              n_cmp++; n_err++;
              $display("FAIL scoreboard_empty: DUT completed an event with nothing expected");
            end else begin
              e = exp_q.pop_front();
              check("latency", 64'(k), 64'(e.gap ? 3 : 2));
              check("steal_pulse_count", 64'(steals), 64'(e.steal));
              check("voice_gate", 64'(voice_gate), 64'(e.gate));
              check("voice_freq", voice_freq, e.freq);
              if (e.gap && gapped)
                check("regap_gate", 64'(gap_gate), 64'(e.gate & ~(one << e.tgt)));
            end
          end
        end else if (steal_pulse) begin
          n_cmp++; n_err++;
          $display("FAIL stray_steal: steal_pulse=1 with no event in flight, required 0");
        end
        if (!busy && ev_valid && ev_ready) begin
          busy = 1; k = 0; steals = 0; gapped = 0;
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 50) begin @(posedge clk); #1; n++; end
    if (exp_q.size() != 0 || busy) begin
      n_cmp++; n_err++;
      $display("FAIL idle_timeout: %0d events still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [FB-1:0] f;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ready", 64'(ev_ready), 64'd1);
    check("reset_gate", 64'(voice_gate), 64'd0);
    check("reset_freq", voice_freq, 64'd0);
    check("reset_steal", 64'(steal_pulse), 64'd0);
    @(posedge clk); #1;
    mon_en = 1;

    send(1, 60, 16'h1234); wait_idle();
    check("first_note_freq_v0", 64'(voice_freq[15:0]), 64'h1234);
    check("first_note_gate_v0", 64'(voice_gate[0]), 64'd1);

    send(1, 62, 16'h2000); send(1, 64, 16'h3000); send(1, 65, 16'h4000);
    send(1, 67, 16'h5555); wait_idle();
    check("steal_v0_freq", 64'(voice_freq[15:0]), 64'h5555);

    send(0, 62, 16'h0); wait_idle();
    check("noteoff_gate_v1", 64'(voice_gate[1]), 64'd0);
    repeat (RCI + 2) begin @(posedge clk); #1; end
    send(1, 69, 16'h6969); wait_idle();
    check("freed_v1_reused", 64'(voice_freq[31:16]), 64'h6969);

    send(0, 70, 16'h0);
    send(1, 64, 16'h3333); wait_idle();
    check("retrigger_v2_freq", 64'(voice_freq[47:32]), 64'h3333);

    for (int i = 0; i < 300; i++) begin
      int g;
      g = (i == 150) ? 300 : int'($urandom_range(0, 12));
      repeat (g) begin @(posedge clk); #1; end
      f = 16'($urandom);
      send(($urandom_range(0, 9) < 6), 60 + int'($urandom_range(0, 7)), f);
    end
    wait_idle();

    mon_en = 0;
    send(1, 72, 16'hBEEF);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    model_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midreset_gate", 64'(voice_gate), 64'd0);
      check("midreset_freq", voice_freq, 64'd0);
    end
    check("midreset_ready", 64'(ev_ready), 64'd1);
    @(posedge clk); #1;
    mon_en = 1;
    send(1, 61, 16'h55AA); wait_idle();
    check("post_reset_v0", 64'(voice_freq[15:0]), 64'h55AA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
